frame_sequencer: RTL and testbench

Controller that sequences the test-pattern frame generator and the frame grabber in simulation and FPGA bring-up. It generates the video timing (fval/lval/dval) and the pixel coordinates x/y. It schedules the pattern select code, either stepping through all six patterns or running one chosen pattern. It also drives the grabber's en so that each pattern's last frame is captured.

---
 rtl/frame_pkg.sv | 31 +++
 rtl/video_timing_gen.sv | 144 ++++++++++++++
 rtl/frame_sequencer.sv | 111 +++++++++++
 tb/tb_frame_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - pattern codes, pattern list, timing states and widths
// Shared by the frame sequencer and its video timing generator.
package frame_pkg;

   localparam int XY_W    = 12;
   localparam int NUM_PAT = 6;

   localparam logic [2:0] SEL_BLACK = 3'b000;
   localparam logic [2:0] SEL_WHITE = 3'b001;
   localparam logic [2:0] SEL_GRAD  = 3'b010;
   localparam logic [2:0] SEL_CHECK = 3'b011;
   localparam logic [2:0] SEL_CUBES = 3'b110;
   localparam logic [2:0] SEL_LOGO  = 3'b111;

   // Entry 0 is played first in a full run.
   localparam logic [NUM_PAT-1:0][2:0] PAT_LIST =
      {SEL_LOGO, SEL_CUBES, SEL_CHECK, SEL_GRAD, SEL_WHITE, SEL_BLACK};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FV_SETUP,
      ST_LINE,
      ST_HBLANK,
      ST_VBLANK
   } state_e;

   function automatic logic sel_valid(input logic [2:0] s);
      return !((s == 3'b100) || (s == 3'b101));
   endfunction

endpackage

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - fval/lval/dval and x/y timing for one frame per frame_go
// SEQ_DVAL_GAP_EN: drop dval on every 8th line cycle, stretching lval to keep WIDTH pixels.
module video_timing_gen
   import frame_pkg::*;
#(
   parameter int WIDTH    = 640,
   parameter int HEIGHT   = 480,
   parameter int H_BLANK  = 16,
   parameter int V_BLANK  = 4,
   parameter int FV_SETUP = 2
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            frame_go,
   output logic            frame_end,
   output logic            vblank_start,
   output logic            fval,
   output logic            lval,
   output logic            dval,
   output logic [XY_W-1:0] x,
   output logic [XY_W-1:0] y
);

   localparam int VB_CYC = V_BLANK * (WIDTH + H_BLANK);
   localparam int MAX_C  = (VB_CYC > FV_SETUP) ? VB_CYC : FV_SETUP;
   localparam int CW     = $clog2(MAX_C + 1);

   state_e          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [XY_W-1:0] x_n, y_n;
   logic            pix;
   logic            fval_n, lval_n, dval_n;
`ifdef SEQ_DVAL_GAP_EN
   logic [2:0]      gc, gc_n;
   assign pix = (gc != 3'd7);
`else
   assign pix = 1'b1;
`endif

   assign frame_end    = (state == ST_VBLANK) && (cnt == CW'(VB_CYC - 1));
   assign vblank_start = (state == ST_LINE) && pix && (x == XY_W'(WIDTH - 1))
                         && (y == XY_W'(HEIGHT - 1));

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      x_n     = x;
      y_n     = y;
`ifdef SEQ_DVAL_GAP_EN
      gc_n    = gc + 3'd1;
`endif
      case (state)
         ST_IDLE: begin
            if (frame_go) begin
               state_n = ST_FV_SETUP;
               cnt_n   = '0;
               x_n     = '0;
               y_n     = '0;
            end
         end
         ST_FV_SETUP: begin
            if (cnt == CW'(FV_SETUP - 1)) begin
               state_n = ST_LINE;
               cnt_n   = '0;
`ifdef SEQ_DVAL_GAP_EN
               gc_n    = '0;
`endif
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         ST_LINE: begin
            // x only advances on cycles that actually carry a pixel
            if (pix) begin
               if (x == XY_W'(WIDTH - 1)) begin
                  cnt_n   = '0;
                  state_n = (y == XY_W'(HEIGHT - 1)) ? ST_VBLANK : ST_HBLANK;
               end else begin
                  x_n = x + XY_W'(1);
               end
            end
         end
         ST_HBLANK: begin
            if (cnt == CW'(H_BLANK - 1)) begin
               state_n = ST_LINE;
               cnt_n   = '0;
               x_n     = '0;
               y_n     = y + XY_W'(1);
`ifdef SEQ_DVAL_GAP_EN
               gc_n    = '0;
`endif
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         ST_VBLANK: begin
            if (frame_end) begin
               state_n = frame_go ? ST_FV_SETUP : ST_IDLE;
               cnt_n   = '0;
               x_n     = '0;
               y_n     = '0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         default: state_n = ST_IDLE;
      endcase
      fval_n = (state_n == ST_FV_SETUP) || (state_n == ST_LINE) || (state_n == ST_HBLANK);
      lval_n = (state_n == ST_LINE);
`ifdef SEQ_DVAL_GAP_EN
      dval_n = lval_n && (gc_n != 3'd7);
`else
      dval_n = lval_n;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         x     <= '0;
         y     <= '0;
         fval  <= 1'b0;
         lval  <= 1'b0;
         dval  <= 1'b0;
`ifdef SEQ_DVAL_GAP_EN
         gc    <= '0;
`endif
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         x     <= x_n;
         y     <= y_n;
         fval  <= fval_n;
         lval  <= lval_n;
         dval  <= dval_n;
`ifdef SEQ_DVAL_GAP_EN
         gc    <= gc_n;
`endif
      end
   end

endmodule

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - schedules pattern codes and frames, drives grabber en
// Timing comes from video_timing_gen; this level owns sel, frame_cnt, en, busy, done, err.
module frame_sequencer
   import frame_pkg::*;
#(
   parameter int WIDTH          = 640,
   parameter int HEIGHT         = 480,
   parameter int H_BLANK        = 16,
   parameter int V_BLANK        = 4,
   parameter int FV_SETUP       = 2,
   parameter int FRAMES_PER_PAT = 1
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            single,
   input  logic [2:0]      sel_in,
   output logic            fval,
   output logic            lval,
   output logic            dval,
   output logic [XY_W-1:0] x,
   output logic [XY_W-1:0] y,
   output logic [2:0]      sel,
   output logic            en,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [7:0]      frame_cnt
);

   if (WIDTH < 1 || WIDTH > 4096 || HEIGHT < 1 || HEIGHT > 4096 || H_BLANK < 1 ||
       V_BLANK < 1 || FV_SETUP < 1 || FRAMES_PER_PAT < 1 || FRAMES_PER_PAT > 255)
   begin : g_param_check
      $error("frame_sequencer: parameter out of range");
   end

   logic       frame_go, frame_end, vblank_start;
   logic       accept, reject, same_pat, next_pat;
   logic       single_r;
   logic [2:0] pidx;

   assign reject   = start && !busy && single && !sel_valid(sel_in);
   assign accept   = start && !busy && !(single && !sel_valid(sel_in));
   // frame_cnt already counts the frame now in vertical blanking
   assign same_pat = frame_cnt < 8'(FRAMES_PER_PAT);
   assign next_pat = !single_r && (pidx != 3'(NUM_PAT - 1));
   assign frame_go = accept || (frame_end && (same_pat || next_pat));

   video_timing_gen #(
      .WIDTH    (WIDTH),
      .HEIGHT   (HEIGHT),
      .H_BLANK  (H_BLANK),
      .V_BLANK  (V_BLANK),
      .FV_SETUP (FV_SETUP)
   ) u_timing (
      .clk          (clk),
      .rst          (rst),
      .frame_go     (frame_go),
      .frame_end    (frame_end),
      .vblank_start (vblank_start),
      .fval         (fval),
      .lval         (lval),
      .dval         (dval),
      .x            (x),
      .y            (y)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         sel       <= '0;
         en        <= 1'b0;
         frame_cnt <= '0;
         single_r  <= 1'b0;
         pidx      <= '0;
      end else begin
         done <= 1'b0;
         err  <= reject;
         if (vblank_start)
            frame_cnt <= frame_cnt + 8'd1;
         // en survives exactly one blanking cycle so the grabber sees the fval fall
         if (busy && !fval)
            en <= 1'b0;
         if (accept) begin
            busy      <= 1'b1;
            single_r  <= single;
            sel       <= single ? sel_in : PAT_LIST[0];
            pidx      <= '0;
            frame_cnt <= '0;
            en        <= (FRAMES_PER_PAT == 1);
         end
         if (frame_end) begin
            if (same_pat) begin
               en <= (frame_cnt + 8'd1 == 8'(FRAMES_PER_PAT));
            end else if (next_pat) begin
               pidx      <= pidx + 3'd1;
               sel       <= PAT_LIST[pidx + 3'd1];
               frame_cnt <= '0;
               en        <= (FRAMES_PER_PAT == 1);
            end else begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - scoreboard bench for frame_sequencer, 1- and 3-frame instances
// Expected per-cycle output traces are built from frame/line/pixel loops and queued per instance.
module tb_frame_sequencer;

   localparam int W  = 4;
   localparam int H  = 2;
   localparam int HB = 2;
   localparam int VB = 1;
   localparam int FS = 2;
`ifdef SEQ_DVAL_GAP_EN
   localparam bit GAP = 1'b1;
`else
   localparam bit GAP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       single = 1'b0;
   logic [2:0] sel_in = 3'd0;

   logic        fval1, lval1, dval1, en1, busy1, done1, err1;
   logic [11:0] x1, y1;
   logic [2:0]  sel1;
   logic [7:0]  fc1;
   logic        fval3, lval3, dval3, en3, busy3, done3, err3;
   logic [11:0] x3, y3;
   logic [2:0]  sel3;
   logic [7:0]  fc3;

   typedef struct {
      logic        fval, lval, dval, en, busy, done, err;
      logic [2:0]  sel;
      logic [7:0]  fc;
      logic [11:0] x, y;
      bit          chk_sf, chk_x, chk_y;
   } ent_t;

   ent_t q1[$];
   ent_t q3[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   frame_sequencer #(.WIDTH(W), .HEIGHT(H), .H_BLANK(HB), .V_BLANK(VB),
                     .FV_SETUP(FS), .FRAMES_PER_PAT(1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .single(single), .sel_in(sel_in),
      .fval(fval1), .lval(lval1), .dval(dval1), .x(x1), .y(y1), .sel(sel1),
      .en(en1), .busy(busy1), .done(done1), .err(err1), .frame_cnt(fc1));

   frame_sequencer #(.WIDTH(W), .HEIGHT(H), .H_BLANK(HB), .V_BLANK(VB),
                     .FV_SETUP(FS), .FRAMES_PER_PAT(3)) dut3 (
      .clk(clk), .rst(rst), .start(start), .single(single), .sel_in(sel_in),
      .fval(fval3), .lval(lval3), .dval(dval3), .x(x3), .y(y3), .sel(sel3),
      .en(en3), .busy(busy3), .done(done3), .err(err3), .frame_cnt(fc3));

   function automatic ent_t blank();
      ent_t e;
      e = '{default: '0};
      return e;
   endfunction

   task automatic push_e(input int which, input ent_t e);
      if (which == 1) q1.push_back(e);
      else            q3.push_back(e);
   endtask

   // One entry per clock, starting with the cycle after start is sampled.
   task automatic push_run(input int which, input int fpp, input bit sg, input logic [2:0] s);
      logic [2:0] pats[$];
      ent_t       e;
      int         px, k;
      bit         gap;
      if (sg) pats.push_back(s);
      else    pats = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
      foreach (pats[pi]) begin
         for (int f = 0; f < fpp; f++) begin
            e = blank();
            e.busy = 1'b1; e.sel = pats[pi]; e.chk_sf = 1'b1;
            e.en = (f == fpp - 1); e.fc = 8'(f); e.fval = 1'b1;
            repeat (FS) push_e(which, e);
            for (int l = 0; l < H; l++) begin
               px = 0; k = 0;
               while (px < W) begin
                  gap = GAP && (k % 8 == 7);
                  e.lval = 1'b1; e.y = 12'(l); e.chk_y = 1'b1;
                  e.dval = !gap; e.chk_x = !gap; e.x = 12'(px);
                  push_e(which, e);
                  if (!gap) px++;
                  k++;
               end
               e.lval = 1'b0; e.dval = 1'b0; e.chk_x = 1'b0; e.chk_y = 1'b0;
               if (l < H - 1) repeat (HB) push_e(which, e);
            end
            e.fval = 1'b0; e.fc = 8'(f + 1);
            for (int j = 0; j < VB * (W + HB); j++) begin
               e.en = (f == fpp - 1) && (j == 0);
               push_e(which, e);
            end
         end
      end
      e = blank();
      e.done = 1'b1; e.sel = pats[pats.size() - 1]; e.fc = 8'(fpp); e.chk_sf = 1'b1;
      push_e(which, e);
   endtask

   task automatic mon(input int which, input logic fv, lv, dv, en_, bz, dn, er,
                      input logic [2:0] s, input logic [7:0] fc, input logic [11:0] xx, yy);
      ent_t e;
      e = blank();
      if (which == 1) begin
         if (q1.size() > 0) e = q1.pop_front();
      end else begin
         if (q3.size() > 0) e = q3.pop_front();
      end
      checks++;
      if ({fv, lv, dv, en_, bz, dn, er} !== {e.fval, e.lval, e.dval, e.en, e.busy, e.done, e.err}) begin
         errors++;
         $display("FAIL ctrl dut%0d t=%0t fval/lval/dval/en/busy/done/err got %b want %b", which, $time,
                  {fv, lv, dv, en_, bz, dn, er}, {e.fval, e.lval, e.dval, e.en, e.busy, e.done, e.err});
      end
      if (e.chk_sf) begin
         checks++;
         if ({s, fc} !== {e.sel, e.fc}) begin
            errors++;
            $display("FAIL sel_fcnt dut%0d t=%0t got sel=%0d cnt=%0d want sel=%0d cnt=%0d",
                     which, $time, s, fc, e.sel, e.fc);
         end
      end
      if (e.chk_x) begin
         checks++;
         if (xx !== e.x) begin
            errors++;
            $display("FAIL x dut%0d t=%0t got %0d want %0d", which, $time, xx, e.x);
         end
      end
      if (e.chk_y) begin
         checks++;
         if (yy !== e.y) begin
            errors++;
            $display("FAIL y dut%0d t=%0t got %0d want %0d", which, $time, yy, e.y);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mon(1, fval1, lval1, dval1, en1, busy1, done1, err1, sel1, fc1, x1, y1);
         mon(3, fval3, lval3, dval3, en3, busy3, done3, err3, sel3, fc3, x3, y3);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input bit sg, input logic [2:0] s, input bit push);
      ent_t e;
      start = 1'b1; single = sg; sel_in = s;
      tick();
      start = 1'b0;
      if (push) begin
         if (sg && (s == 3'b100 || s == 3'b101)) begin
            e = blank();
            e.err = 1'b1;
            push_e(1, e);
            push_e(3, e);
         end else begin
            push_run(1, 1, sg, s);
            push_run(3, 3, sg, s);
         end
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((q1.size() != 0 || q3.size() != 0) && n < 3000) begin
         tick();
         n++;
      end
      checks++;
      if (n >= 3000) begin
         errors++;
         $display("FAIL drain got %0d/%0d pending want 0/0", q1.size(), q3.size());
         q1.delete();
         q3.delete();
      end
   endtask

   task automatic check_all_zero(input string nm);
      checks++;
      if ({fval1, lval1, dval1, en1, busy1, done1, err1, sel1, fc1, x1, y1,
           fval3, lval3, dval3, en3, busy3, done3, err3, sel3, fc3, x3, y3} !== '0) begin
         errors++;
         $display("FAIL %s got busy=%b/%b fval=%b/%b sel=%0d/%0d cnt=%0d/%0d x=%0d y=%0d want all 0",
                  nm, busy1, busy3, fval1, fval3, sel1, sel3, fc1, fc3, x1, y1);
      end
   endtask

   initial begin
      int n;
      #1 rst = 1'b1;
      #3 check_all_zero("reset_state");
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      repeat (3) tick();

      // Single pattern; a second start lands on the exit-to-idle edge and is ignored.
      start_run(1'b1, 3'b011, 1'b1);
      repeat (17) tick();
      start_run(1'b1, 3'b110, 1'b0);
      wait_idle();

      // Full list; starts issued mid-run are ignored, including an invalid one.
      start_run(1'b0, 3'b000, 1'b1);
      repeat (10) tick();
      start_run(1'b1, 3'b111, 1'b0);
      start_run(1'b1, 3'b100, 1'b0);
      wait_idle();

      // Rejected codes.
      start_run(1'b1, 3'b101, 1'b1);
      wait_idle();
      start_run(1'b1, 3'b100, 1'b1);
      wait_idle();

      // Reset in the middle of a line.
      start_run(1'b1, 3'b010, 1'b1);
      n = 0;
      @(negedge clk);
      while (!(lval1 && x1 == 12'd2) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL reach_x2 got no lval with x=2 want one within 100 cycles");
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({fval1, lval1, dval1, fval3, lval3, dval3} !== 6'b0) begin
         errors++;
         $display("FAIL async_rst got fval/lval/dval=%b%b%b/%b%b%b want 000/000",
                  fval1, lval1, dval1, fval3, lval3, dval3);
      end
      q1.delete();
      q3.delete();
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      #1 check_all_zero("post_reset");
      repeat (6) tick();

      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(0, 4)) tick();
         start_run(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b1);
         wait_idle();
      end
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got no finish want finish before 1000000");
      $fatal(1, "watchdog");
   end

endmodule
